prog_mem_loader: RTL
====================

// Module: prog_mem_loader
// PURPOSE
//  Writer side of the program memory: streams 32-bit instruction words into the
//  byte-wide memory, one byte per cycle, in the order the fetch states read them
//  (addr+0 -> Instruction[7:0] ... addr+3 -> Instruction[31:24]). Holds the
//  processor in reset (cpu_reset) until the last word is written, then releases it.
// PARAMETERS
//  ADDR_W     8    memory address width
//  MEM_DEPTH  256  bytes in program memory; highest legal byte address MEM_DEPTH-1
//  BASE_ADDR  0    byte address of the first instruction (the PC reset value)
// PORTS
//  ph1         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  in_valid    in   1       in_word/in_last valid
//  in_word     in   32      instruction word
//  in_last     in   1       marks the final word of the program
//  in_ready    out  1       loader accepts a word this cycle
//  MemWrite    out  1       byte write strobe to memory
//  Address     out  ADDR_W  byte address of the write
//  Write_data  out  8       byte to write
//  cpu_reset   out  1       reset to the processor; 1 until load completes
//  done        out  1       load finished, processor released
//  error       out  1       program overflowed memory
//  word_count  out  ADDR_W  words fully written since reset
// BEHAVIOUR
//  Reset (async): state=IDLE, addr_ptr=BASE_ADDR, byte_idx=0, word_count=0,
//   MemWrite=0, Write_data=0, Address=BASE_ADDR, cpu_reset=1, done=0, error=0,
//   in_ready=0 while reset is high. Reset mid-write discards the partial word;
//   MemWrite drops immediately, not on the next edge.
//  States IDLE, WRITE, DONE, ERR.
//  IDLE: in_ready=1. Transfer when in_valid & in_ready at a ph1 edge: latch
//   in_word and in_last. If addr_ptr > MEM_DEPTH-4 -> ERR, with no bytes written.
//   Otherwise -> WRITE with byte_idx=0.
//  WRITE: in_ready=0. MemWrite=1, Address=addr_ptr, Write_data=word[8*byte_idx+7 -: 8].
//   Each edge: addr_ptr+=1, byte_idx+=1.
//   At byte_idx==3: word_count+=1; latched last ? DONE : IDLE.
//  Timing: one word = 1 accept cycle + 4 write cycles (5 cycles/word). The first
//   write is in the cycle after acceptance.
//  DONE: cpu_reset=0, done=1, in_ready=0, MemWrite=0. Stays here until reset;
//   in_valid is ignored.
//  ERR: error=1, cpu_reset=1, in_ready=0, MemWrite=0. Stays here until reset.
//  addr_ptr never wraps. A word based at MEM_DEPTH-4 is legal; the next accepted
//   word flags ERR.
//  A single word with in_last=1 is a valid program. in_valid while not ready has
//   no effect. The source must hold in_word/in_last stable until the transfer.
//  All outputs other than in_ready are functions of registered state only.
// TESTING
//  1) Reset, push 0x20010005 with last=1 -> writes 05,00,01,20 @0..3 on 4
//     consecutive cycles; next cycle done=1, cpu_reset=0, word_count=1.
//  2) Push 3 words, last on the 3rd -> 12 writes @0..11, byte order as in (1);
//     in_ready low during each WRITE; word_count=3; done after the 15th cycle.
//  3) in_valid held high with changing data while in WRITE -> ignored; only the
//     accepted words are written; no byte is lost or duplicated.
//  4) MEM_DEPTH=8: two words write @0..7; a third push -> error=1, no MemWrite,
//     cpu_reset stays 1.
//  5) Assert reset during the 2nd byte of a word -> MemWrite=0 at once; after
//     release Address=BASE_ADDR; reloading from word 0 completes normally.
//  6) BASE_ADDR=16: one word with last=1 -> writes @16..19; in_valid after done
//     -> no writes, done stays 1.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Program memory loader: streams 32-bit words into byte-wide memory, LSB first,
// holding the processor in reset until the final word has been written.
module prog_mem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              in_ready,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [7:0]        Write_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE,
        ERR
    } state_t;

    // One extra pointer bit so the pointer reaches MEM_DEPTH instead of wrapping
    localparam logic [ADDR_W:0] PTR_RST = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] PTR_MAX = (ADDR_W + 1)'(MEM_DEPTH - 4);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            idx_q   <= 2'd0;
            word_q  <= 32'h0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        word_d   = word_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        in_ready = (state_q == IDLE) && !reset;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d = in_word;
                    last_d = in_last;
                    if (ptr_q > PTR_MAX) begin
                        state_d = ERR;
                    end else begin
                        state_d = WRITE;
                        idx_d   = 2'd0;
                    end
                end
            end
            WRITE: begin
                ptr_d = ptr_q + 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_q ? DONE : IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    assign MemWrite   = (state_q == WRITE);
    assign Address    = ptr_q[ADDR_W-1:0];
    assign Write_data = MemWrite ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign cpu_reset  = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign word_count = cnt_q;

endmodule
